// File: rtl/lock_entry_controller.sv
// Combination-lock sequencer: collects keypad digits, checks them against a stored code,
// drives the actuator, counts failures with timed lockout, and allows reprogramming while open.
module lock_entry_controller #(
    parameter int                          DIGITS         = 4,
    parameter int                          DIGIT_W        = 4,
    parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
    parameter int                          MAX_TRIES      = 3,
    parameter int                          OPEN_CYCLES    = 50_000_000,
    parameter int                          LOCKOUT_CYCLES = 500_000_000,
    parameter int                          TIMEOUT_CYCLES = 250_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_digit,
    input  logic               key_enter,
    input  logic               key_clear,
    input  logic               prog_req,
    output logic               unlock,
    output logic               alarm,
    output logic               busy,
    output logic [2:0]         fail_count,
    output logic [3:0]         digit_count,
    output logic [2:0]         state_o
);

    localparam int CODE_W = DIGITS * DIGIT_W;
    localparam int T_MAX  = (OPEN_CYCLES > LOCKOUT_CYCLES) ?
                            ((OPEN_CYCLES > TIMEOUT_CYCLES) ? OPEN_CYCLES : TIMEOUT_CYCLES) :
                            ((LOCKOUT_CYCLES > TIMEOUT_CYCLES) ? LOCKOUT_CYCLES : TIMEOUT_CYCLES);
    localparam int TW     = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] T_OPEN = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_IDLE = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_LOCKOUT = 3'd4,
        S_PROG    = 3'd5
    } state_t;

    state_t              state, state_next;
    logic [TW-1:0]       timer;
    logic [CODE_W-1:0]   entry_buf;
    logic [CODE_W-1:0]   code;

    logic clr, ent, dig;
    logic timer_done, match, prog_commit, digit_accept, collecting;
    logic [2:0] fail_next;

    // Only the highest-priority strobe of a cycle is acted on.
    assign clr = key_clear;
    assign ent = key_enter & ~key_clear;
    assign dig = key_valid & ~key_enter & ~key_clear;

    assign timer_done  = (timer == '0);
    assign match       = (digit_count == 4'(DIGITS)) && (entry_buf == code);
    assign fail_next   = fail_count + 3'd1;
    assign prog_commit = (state == S_PROG) && prog_req && ent && (digit_count == 4'(DIGITS));
    assign collecting  = (state == S_IDLE) || (state == S_ENTRY) || (state == S_PROG);
    assign digit_accept = dig && collecting &&
                          ((state_next == S_ENTRY) || (state_next == S_PROG));

    function automatic logic [TW-1:0] reload_value(input state_t s);
        case (s)
            S_OPEN:            reload_value = T_OPEN;
            S_LOCKOUT:         reload_value = T_LOCK;
            S_ENTRY, S_PROG:   reload_value = T_IDLE;
            default:           reload_value = '0;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (clr)      state_next = S_IDLE;
                else if (ent) state_next = S_CHECK;
                else if (dig) state_next = S_ENTRY;
            end
            S_ENTRY: begin
                if (clr)             state_next = S_IDLE;
                else if (ent)        state_next = S_CHECK;
                else if (dig)        state_next = S_ENTRY;
                else if (timer_done) state_next = S_IDLE;
            end
            S_CHECK: begin
                if (match)                          state_next = S_OPEN;
                else if (fail_next == 3'(MAX_TRIES)) state_next = S_LOCKOUT;
                else                                state_next = S_IDLE;
            end
            S_OPEN: begin
                if (prog_req)        state_next = S_PROG;
                else if (timer_done) state_next = S_IDLE;
            end
            S_PROG: begin
                if (!prog_req || clr || ent) state_next = S_IDLE;
                else if (dig)               state_next = S_PROG;
                else if (timer_done)        state_next = S_IDLE;
            end
            S_LOCKOUT: begin
                if (timer_done) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        unlock  = (state == S_OPEN) || (state == S_PROG);
        alarm   = (state == S_LOCKOUT);
        busy    = (state == S_CHECK) || (state == S_LOCKOUT);
        state_o = state;
    end

    // Shared timer: reloaded on every state change and on any strobe while collecting digits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            timer <= '0;
        else if (state_next != state)
            timer <= reload_value(state_next);
        else if (((state == S_ENTRY) || (state == S_PROG)) && (key_valid || key_enter || key_clear))
            timer <= T_IDLE;
        else if (!timer_done)
            timer <= timer - TW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_buf   <= '0;
            digit_count <= '0;
            code        <= DEFAULT_CODE;
            fail_count  <= '0;
        end else begin
            if (prog_commit)
                code <= entry_buf;

            // The entry survives only while collecting or being checked; a count of DIGITS+1 flags overflow.
            if (!(state_next inside {S_ENTRY, S_PROG, S_CHECK})) begin
                entry_buf   <= '0;
                digit_count <= '0;
            end else if (digit_accept && (digit_count <= 4'(DIGITS))) begin
                entry_buf   <= {entry_buf[CODE_W-DIGIT_W-1:0], key_digit};
                digit_count <= digit_count + 4'd1;
            end

            if (state == S_CHECK)
                fail_count <= match ? 3'd0 : fail_next;
            else if ((state == S_LOCKOUT) && timer_done)
                fail_count <= 3'd0;
        end
    end

endmodule

// File: doc/lock_entry_controller.md
# lock_entry_controller

Sequencing controller for the digital combination lock. It collects a multi-digit code from a keypad strobe interface and compares it against a stored code. It counts failed attempts, holds the actuator open for a fixed time on success, and enforces a timed lockout with alarm after too many failures. While open, it also lets the user reprogram the stored code. It sits between the keypad scanner and the lock actuator/LED drivers.

## Interface
- DIGITS, 4: digits per code (2..8)
- DIGIT_W, 4: bits per digit
- DEFAULT_CODE, 16'h1234: code loaded at reset (DIGITS*DIGIT_W bits, digit 0 in MSBs)
- MAX_TRIES, 3: consecutive failures that trigger lockout (1..7)
- OPEN_CYCLES, 50_000_000: cycles unlock stays asserted
- LOCKOUT_CYCLES, 500_000_000: lockout duration in cycles
- TIMEOUT_CYCLES, 250_000_000: inter-key idle limit during entry/programming
- clk  in  1  clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- key_valid  in  1  one-cycle strobe: key_digit is valid
- key_digit  in  DIGIT_W  digit value
- key_enter  in  1  one-cycle strobe: submit entry
- key_clear  in  1  one-cycle strobe: discard current entry
- prog_req  in  1  level; request programming mode (honoured only in OPEN)
- unlock  out  1  actuator release (1 = open)
- alarm  out  1  high throughout LOCKOUT
- busy  out  1  high in CHECK or LOCKOUT; keys ignored
- fail_count  out  3  consecutive failed attempts
- digit_count  out  4  digits captured in current entry
- state_o  out  3  IDLE=0, ENTRY=1, CHECK=2, OPEN=3, LOCKOUT=4, PROG=5

## Operation
- Reset values: state IDLE, unlock 0, alarm 0, busy 0, fail_count 0, digit_count 0, entry buffer 0, stored code = DEFAULT_CODE.
- Input priority per cycle: key_clear > key_enter > key_valid. Lower-priority strobes in the same cycle are dropped.
- IDLE: key_valid captures the digit, sets digit_count=1, and moves to ENTRY. key_enter alone counts as a failed attempt and goes to CHECK with digit_count 0.
- ENTRY:
  - key_valid shifts the digit in, LSB side, and increments digit_count.
  - digit_count saturates at DIGITS+1. That value marks overflow, and further digits are ignored.
  - key_enter goes to CHECK.
  - key_clear, or TIMEOUT_CYCLES with no strobe, goes to IDLE. The buffer and digit_count are zeroed, and no failure is counted.
- CHECK (exactly 1 cycle): the entry is a match iff digit_count==DIGITS and buffer==stored code.
  - Match: goes to OPEN, fail_count<=0.
  - Mismatch: fail_count+1. If the new value equals MAX_TRIES, go to LOCKOUT; otherwise go to IDLE.
  - The buffer and digit_count clear on exit in both cases.
- OPEN: unlock=1 for OPEN_CYCLES, then return to IDLE. key_valid/enter/clear are ignored. prog_req=1 goes to PROG on the next edge.
- PROG:
  - unlock stays 1.
  - Digits are collected exactly as in ENTRY.
  - key_enter with digit_count==DIGITS writes the buffer into the stored code and goes to IDLE.
  - key_enter with any other count, key_clear, timeout, or prog_req dropping abandons the change and goes to IDLE.
  - Failures are never counted in PROG.
- LOCKOUT: alarm=1 and busy=1, all keys ignored. After LOCKOUT_CYCLES, fail_count<=0 and the state goes to IDLE.
- Timer: a single shared down-counter sized for max(OPEN, LOCKOUT, TIMEOUT). It reloads on every state entry and on every accepted strobe in ENTRY/PROG.

## Timing
- All outputs are registered and decoded from state, with no combinational input-to-output path.
- Latency to unlock: key_enter at edge N puts CHECK in cycle N+1 and unlock=1 from edge N+2.
- OPEN lasts exactly OPEN_CYCLES cycles, LOCKOUT exactly LOCKOUT_CYCLES, and timeout fires on the TIMEOUT_CYCLES-th idle cycle.
- digit_count updates on the edge following key_valid.
- The stored code updates on the edge that accepts key_enter in PROG. The new code is used by the next CHECK.
- Reset mid-operation (any state) immediately forces the reset values.
  - The stored code also returns to DEFAULT_CODE, so a programmed code is volatile.
- prog_req asserted outside OPEN has no effect and is not latched.

## Test plan
Bench parameters: DIGITS=4, DEFAULT_CODE=16'h1234, MAX_TRIES=3, OPEN=8, LOCKOUT=16, TIMEOUT=10.
- Keys 1,2,3,4 then enter -> state_o CHECK for 1 cycle, then unlock=1 for exactly 8 cycles, fail_count 0, then IDLE.
- Enter 1,2,3,5 three times -> fail_count goes 1, 2, then LOCKOUT. alarm=busy=1 for 16 cycles, keys ignored, then fail_count 0 and IDLE.
- Enter 1,2,3 then enter (short entry), and separately 1,2,3,4,5 then enter (digit_count saturates at 5) -> both count as failures, unlock stays 0.
- Two digits then 10 idle cycles -> IDLE, digit_count 0, fail_count unchanged. Same result with key_clear instead of waiting.
- In OPEN, assert prog_req and enter 9,8,7,6 then enter -> IDLE. Code 1234 now fails and 9876 unlocks. After reset, 1234 unlocks again.
- key_clear and key_enter together in ENTRY -> entry discarded, no CHECK. Reset asserted in OPEN -> unlock 0 immediately and all outputs return to reset values.
